// File: rtl/ex_mem_branch_reg_if.sv
// EX/MEM boundary bundle: EX-stage instruction fields in, MEM-stage fields and PC redirect out.
// Latency: none (wires only).
// Backpressure: stall/flush travel with the bundle; the register side honours them.
interface ex_mem_branch_reg_if;
    // Pipeline control from the MEM stage / hazard unit
    logic        stall;
    logic        flush;
    // EX-stage instruction
    logic        in_valid;
    logic [31:0] alu_result;
    logic        eq_flag;
    logic        lt_flag;
    logic        ltu_flag;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] store_data;
    logic [4:0]  rd_addr;
    logic        reg_write_en;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  wb_sel;
    // MEM-stage view and redirect
    logic        out_valid;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [31:0] out_pc_plus4;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write_en;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [1:0]  out_wb_sel;
    logic        branch_taken;
    logic [31:0] branch_target;

    modport master (
        output stall, flush, in_valid, alu_result, eq_flag, lt_flag, ltu_flag,
               branch, jump, funct3, target, pc_plus4, store_data, rd_addr,
               reg_write_en, mem_read, mem_write, wb_sel,
        input  out_valid, out_alu_result, out_store_data, out_pc_plus4, out_rd_addr,
               out_reg_write_en, out_mem_read, out_mem_write, out_wb_sel,
               branch_taken, branch_target
    );

    modport slave (
        input  stall, flush, in_valid, alu_result, eq_flag, lt_flag, ltu_flag,
               branch, jump, funct3, target, pc_plus4, store_data, rd_addr,
               reg_write_en, mem_read, mem_write, wb_sel,
        output out_valid, out_alu_result, out_store_data, out_pc_plus4, out_rd_addr,
               out_reg_write_en, out_mem_read, out_mem_write, out_wb_sel,
               branch_taken, branch_target
    );
endinterface

// File: rtl/ex_mem_branch_reg.sv
// EX/MEM pipeline register with branch resolution, one-cycle redirect and wrong-path squash.
// Latency: 1 cycle from EX inputs to MEM outputs and to the redirect pulse.
// Backpressure: stall holds every register and the FSM; the redirect pulse is cleared, never replayed.
module ex_mem_branch_reg #(
    parameter int unsigned SQUASH_CYCLES = 2
) (
    input logic               clk,
    input logic               rst_n,
    ex_mem_branch_reg_if.slave bus
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  sq_cnt_q;
    logic [2:0]  sq_cnt_d;

    logic        cond;
    logic        v;
    logic        taken;

    // Decode branch condition and form the effective valid / redirect decision
    always_comb begin
        cond = 1'b0;
        case (bus.funct3)
            3'b000:  cond =  bus.eq_flag;
            3'b001:  cond = ~bus.eq_flag;
            3'b100:  cond =  bus.lt_flag;
            3'b101:  cond = ~bus.lt_flag;
            3'b110:  cond =  bus.ltu_flag;
            3'b111:  cond = ~bus.ltu_flag;
            default: cond = 1'b0;
        endcase
        // Wrong-path instructions arriving during SQUASH are never valid and never redirect
        v     = bus.in_valid & ~bus.flush & (state_q == RUN);
        taken = v & (bus.jump | (bus.branch & cond));
    end

    // Next state: enter SQUASH on a captured redirect, count down bubbles, return at 1->0
    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        if (!bus.stall) begin
            case (state_q)
                RUN: begin
                    if (taken) begin
                        state_d  = SQUASH;
                        sq_cnt_d = 3'(SQUASH_CYCLES);
                    end
                end
                SQUASH: begin
                    // Flush does not pause the countdown: every unstalled edge is one killed slot
                    if (sq_cnt_q <= 3'd1) begin
                        state_d  = RUN;
                        sq_cnt_d = 3'd0;
                    end else begin
                        sq_cnt_d = sq_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d  = RUN;
                    sq_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // FSM state and squash counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            sq_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    // Pipeline payload: enables gated by effective valid, data captured raw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid        <= 1'b0;
            bus.out_alu_result   <= 32'd0;
            bus.out_store_data   <= 32'd0;
            bus.out_pc_plus4     <= 32'd0;
            bus.out_rd_addr      <= 5'd0;
            bus.out_reg_write_en <= 1'b0;
            bus.out_mem_read     <= 1'b0;
            bus.out_mem_write    <= 1'b0;
            bus.out_wb_sel       <= 2'd0;
        end else if (!bus.stall) begin
            bus.out_valid        <= v;
            bus.out_alu_result   <= bus.alu_result;
            bus.out_store_data   <= bus.store_data;
            bus.out_pc_plus4     <= bus.pc_plus4;
            bus.out_rd_addr      <= bus.rd_addr;
            bus.out_reg_write_en <= bus.reg_write_en & v;
            bus.out_mem_read     <= bus.mem_read & v;
            bus.out_mem_write    <= bus.mem_write & v;
            bus.out_wb_sel       <= bus.wb_sel;
        end
    end

    // Redirect pulse: cleared on a stalled edge so a held branch never fetches twice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.branch_taken  <= 1'b0;
            bus.branch_target <= 32'd0;
        end else if (bus.stall) begin
            bus.branch_taken  <= 1'b0;
        end else begin
            bus.branch_taken  <= taken;
            bus.branch_target <= bus.target;
        end
    end

endmodule

// File: tb/tb_ex_mem_branch_reg.sv
// Self-checking bench: directed literal scenarios plus randomized traffic against a behavioural model.
// Latency: model predicts outputs one edge after inputs.
// Backpressure: stall/flush/reset injected randomly and in directed cases.
module tb_ex_mem_branch_reg;

    localparam int SQ = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ex_mem_branch_reg_if bus();

    ex_mem_branch_reg #(.SQUASH_CYCLES(SQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors   = 0;
    int miscompares = 0;
    bit cmp_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid  = 1'b0;
    logic [31:0] m_alu    = 32'd0;
    logic [31:0] m_store  = 32'd0;
    logic [31:0] m_pc4    = 32'd0;
    logic [4:0]  m_rd     = 5'd0;
    logic        m_rwe    = 1'b0;
    logic        m_mr     = 1'b0;
    logic        m_mw     = 1'b0;
    logic [1:0]  m_wb     = 2'd0;
    logic        m_taken  = 1'b0;
    logic [31:0] m_target = 32'd0;
    int          squash_left = 0;

    function automatic logic branch_cond(input logic [2:0] f3, input logic eq,
                                         input logic lt, input logic ltu);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            3'd7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        logic v, tk;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_valid = 0; m_alu = 0; m_store = 0; m_pc4 = 0; m_rd = 0;
                m_rwe = 0; m_mr = 0; m_mw = 0; m_wb = 0; m_taken = 0; m_target = 0;
                squash_left = 0;
            end else if (bus.stall) begin
                m_taken = 1'b0;
            end else begin
                v  = bus.in_valid && !bus.flush && (squash_left == 0);
                tk = v && (bus.jump || (bus.branch &&
                     branch_cond(bus.funct3, bus.eq_flag, bus.lt_flag, bus.ltu_flag)));
                m_valid  = v;
                m_alu    = bus.alu_result;
                m_store  = bus.store_data;
                m_pc4    = bus.pc_plus4;
                m_rd     = bus.rd_addr;
                m_rwe    = bus.reg_write_en & v;
                m_mr     = bus.mem_read & v;
                m_mw     = bus.mem_write & v;
                m_wb     = bus.wb_sel;
                m_taken  = tk;
                m_target = bus.target;
                if (squash_left > 0) squash_left--;
                else if (tk)        squash_left = SQ;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("valid", 32'(bus.out_valid),        32'(m_valid));
                check("taken", 32'(bus.branch_taken),     32'(m_taken));
                check("rwe",   32'(bus.out_reg_write_en), 32'(m_rwe));
                check("mrd",   32'(bus.out_mem_read),     32'(m_mr));
                check("mwr",   32'(bus.out_mem_write),    32'(m_mw));
                if (m_valid) begin
                    check("alu",   bus.out_alu_result,   m_alu);
                    check("store", bus.out_store_data,   m_store);
                    check("pc4",   bus.out_pc_plus4,     m_pc4);
                    check("rd",    32'(bus.out_rd_addr), 32'(m_rd));
                    check("wb",    32'(bus.out_wb_sel),  32'(m_wb));
                end
                if (m_taken)
                    check("target", bus.branch_target, m_target);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        bus.stall = 0; bus.flush = 0; bus.in_valid = 0; bus.alu_result = 0;
        bus.eq_flag = 0; bus.lt_flag = 0; bus.ltu_flag = 0; bus.branch = 0;
        bus.jump = 0; bus.funct3 = 0; bus.target = 0; bus.pc_plus4 = 0;
        bus.store_data = 0; bus.rd_addr = 0; bus.reg_write_en = 0;
        bus.mem_read = 0; bus.mem_write = 0; bus.wb_sel = 0;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_valid",  32'(bus.out_valid),    32'd0);
        check("rst_taken",  32'(bus.branch_taken), 32'd0);
        check("rst_alu",    bus.out_alu_result,    32'd0);
        check("rst_target", bus.branch_target,     32'd0);
        rst_n = 1'b1;

        // Plain ALU op
        @(negedge clk);
        bus.in_valid = 1; bus.alu_result = 32'd30; bus.reg_write_en = 1; bus.rd_addr = 5'd5;
        edge_sample();
        check("t1_alu",   bus.out_alu_result,        32'd30);
        check("t1_rd",    32'(bus.out_rd_addr),      32'd5);
        check("t1_valid", 32'(bus.out_valid),        32'd1);
        check("t1_rwe",   32'(bus.out_reg_write_en), 32'd1);

        // Taken BEQ, then two squashed slots, then a valid one
        @(negedge clk);
        bus.branch = 1; bus.funct3 = 3'b000; bus.eq_flag = 1; bus.target = 32'h100;
        bus.pc_plus4 = 32'h44; bus.reg_write_en = 0; bus.alu_result = 32'd0;
        edge_sample();
        check("t2_taken",  32'(bus.branch_taken), 32'd1);
        check("t2_target", bus.branch_target,     32'h100);
        check("t2_valid",  32'(bus.out_valid),    32'd1);
        check("t2_pc4",    bus.out_pc_plus4,      32'h44);
        @(negedge clk);
        bus.branch = 0; bus.eq_flag = 0; bus.alu_result = 32'd1; bus.reg_write_en = 1;
        edge_sample();
        check("t2_drop",   32'(bus.branch_taken), 32'd0);
        check("t2_sq1",    32'(bus.out_valid),    32'd0);
        check("t2_sq1rwe", 32'(bus.out_reg_write_en), 32'd0);
        @(negedge clk);
        bus.alu_result = 32'd2;
        edge_sample();
        check("t2_sq2", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        bus.alu_result = 32'd3;
        edge_sample();
        check("t2_resume", 32'(bus.out_valid),   32'd1);
        check("t2_alu3",   bus.out_alu_result,   32'd3);

        // BGE with LT set: not taken, no squash
        @(negedge clk);
        bus.branch = 1; bus.funct3 = 3'b101; bus.lt_flag = 1;
        edge_sample();
        check("t3_taken", 32'(bus.branch_taken), 32'd0);
        check("t3_valid", 32'(bus.out_valid),    32'd1);
        @(negedge clk);
        bus.branch = 0; bus.lt_flag = 0; bus.alu_result = 32'd7;
        edge_sample();
        check("t3_next", 32'(bus.out_valid), 32'd1);
        check("t3_alu",  bus.out_alu_result, 32'd7);

        // Taken branch followed by a three-cycle stall
        @(negedge clk);
        bus.branch = 1; bus.funct3 = 3'b000; bus.eq_flag = 1; bus.target = 32'h200;
        bus.alu_result = 32'h55;
        edge_sample();
        check("t4_taken", 32'(bus.branch_taken), 32'd1);
        @(negedge clk);
        bus.stall = 1; bus.branch = 0; bus.eq_flag = 0; bus.alu_result = 32'd9;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            check("t4_stall_taken", 32'(bus.branch_taken), 32'd0);
            check("t4_stall_valid", 32'(bus.out_valid),    32'd1);
            check("t4_stall_alu",   bus.out_alu_result,    32'h55);
        end
        @(negedge clk);
        bus.stall = 0;
        edge_sample();
        check("t4_sq1", 32'(bus.out_valid), 32'd0);
        check("t4_sq1_taken", 32'(bus.branch_taken), 32'd0);
        edge_sample();
        check("t4_sq2", 32'(bus.out_valid), 32'd0);
        edge_sample();
        check("t4_resume", 32'(bus.out_valid), 32'd1);
        check("t4_alu",    bus.out_alu_result, 32'd9);

        // Flush under stall holds; flushed jump neither commits nor redirects
        @(negedge clk);
        bus.alu_result = 32'h11;
        edge_sample();
        @(negedge clk);
        bus.stall = 1; bus.flush = 1; bus.alu_result = 32'h22;
        edge_sample();
        check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
        check("t5_hold_alu",   bus.out_alu_result, 32'h11);
        @(negedge clk);
        bus.stall = 0; bus.jump = 1; bus.target = 32'h300;
        edge_sample();
        check("t5_fl_valid", 32'(bus.out_valid),        32'd0);
        check("t5_fl_taken", 32'(bus.branch_taken),     32'd0);
        check("t5_fl_rwe",   32'(bus.out_reg_write_en), 32'd0);
        @(negedge clk);
        bus.flush = 0; bus.jump = 0; bus.alu_result = 32'h33;
        edge_sample();
        check("t5_next_valid", 32'(bus.out_valid), 32'd1);
        check("t5_next_alu",   bus.out_alu_result, 32'h33);

        // JAL commits its link, then reset arrives mid-squash
        @(negedge clk);
        bus.jump = 1; bus.target = 32'h400; bus.pc_plus4 = 32'h48; bus.rd_addr = 5'd1;
        edge_sample();
        check("t6_taken", 32'(bus.branch_taken), 32'd1);
        check("t6_valid", 32'(bus.out_valid),    32'd1);
        check("t6_link",  bus.out_pc_plus4,      32'h48);
        check("t6_rd",    32'(bus.out_rd_addr),  32'd1);
        @(negedge clk);
        bus.jump = 0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.out_valid),    32'd0);
        check("t6_rst_taken", 32'(bus.branch_taken), 32'd0);
        check("t6_rst_pc4",   bus.out_pc_plus4,      32'd0);
        @(negedge clk);
        rst_n = 1'b1; bus.alu_result = 32'h66;
        edge_sample();
        check("t6_after_valid", 32'(bus.out_valid), 32'd1);
        check("t6_after_alu",   bus.out_alu_result, 32'h66);

        // Randomized traffic; the compare process checks every cycle
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            bus.stall        = ($urandom_range(0, 7) == 0);
            bus.flush        = ($urandom_range(0, 9) == 0);
            bus.in_valid     = ($urandom_range(0, 5) != 0);
            bus.alu_result   = $urandom;
            bus.eq_flag      = 1'($urandom_range(0, 1));
            bus.lt_flag      = 1'($urandom_range(0, 1));
            bus.ltu_flag     = 1'($urandom_range(0, 1));
            bus.branch       = ($urandom_range(0, 2) == 0);
            bus.jump         = ($urandom_range(0, 9) == 0);
            bus.funct3       = 3'($urandom_range(0, 7));
            bus.target       = $urandom;
            bus.pc_plus4     = $urandom;
            bus.store_data   = $urandom;
            bus.rd_addr      = 5'($urandom_range(0, 31));
            bus.reg_write_en = 1'($urandom_range(0, 1));
            bus.mem_read     = 1'($urandom_range(0, 1));
            bus.mem_write    = 1'($urandom_range(0, 1));
            bus.wb_sel       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        set_idle();
        repeat (4) @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
